// File: rtl/mux_2x1_rr_arbiter.sv
// mux_2x1_rr_arbiter: round-robin arbiter for two valid/ready streams feeding a
// one-entry registered output stage that reports the source index on SEL. Rev 1.0
`default_nettype none

module mux_2x1_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             I0_VALID,
  input  logic [WIDTH-1:0] I0_DATA,
  output logic             I0_READY,
  input  logic             I1_VALID,
  input  logic [WIDTH-1:0] I1_DATA,
  output logic             I1_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             SEL
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             sel_q,       sel_d;
  logic             prio_q,      prio_d;

  logic             load_w;
  logic             grant_w;
  logic             gnt_w;

  // Grant logic; RSTn gating keeps both READYs low while reset is held.
  always_comb begin
    load_w  = !out_valid_q || OUT_READY;
    grant_w = 1'b0;
    gnt_w   = prio_q;
    if (RSTn && load_w) begin
      case ({I1_VALID, I0_VALID})
        2'b01: begin
          grant_w = 1'b1;
          gnt_w   = 1'b0;
        end
        2'b10: begin
          grant_w = 1'b1;
          gnt_w   = 1'b1;
        end
        2'b11: begin
          grant_w = 1'b1;
          gnt_w   = prio_q;
        end
        default: begin
          grant_w = 1'b0;
          gnt_w   = prio_q;
        end
      endcase
    end
  end

  assign I0_READY = grant_w && !gnt_w;
  assign I1_READY = grant_w &&  gnt_w;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    prio_d      = prio_q;
    if (grant_w) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_w ? I1_DATA : I0_DATA;
      sel_d       = gnt_w;
      prio_d      = !gnt_w;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
      prio_q      <= prio_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign SEL       = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Directed testbench for mux_2x1_rr_arbiter with hand-computed expectations.
`default_nettype none

module tb_mux_2x1_rr_arbiter;

  localparam int WIDTH = 4;

  logic             CLK;
  logic             RSTn;
  logic             I0_VALID;
  logic [WIDTH-1:0] I0_DATA;
  logic             I0_READY;
  logic             I1_VALID;
  logic [WIDTH-1:0] I1_DATA;
  logic             I1_READY;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             SEL;

  int checks = 0;
  int errors = 0;

  mux_2x1_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .I0_VALID  (I0_VALID),
    .I0_DATA   (I0_DATA),
    .I0_READY  (I0_READY),
    .I1_VALID  (I1_VALID),
    .I1_DATA   (I1_DATA),
    .I1_READY  (I1_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .SEL       (SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, {31'd0, I0_READY}, {31'd0, r0});
    chk({tag, "_rdy1"}, {31'd0, I1_READY}, {31'd0, r1});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic s, input logic [WIDTH-1:0] d);
    chk({tag, "_valid"}, {31'd0, OUT_VALID}, {31'd0, v});
    chk({tag, "_sel"},   {31'd0, SEL},       {31'd0, s});
    chk({tag, "_data"},  {28'd0, OUT_DATA},  {28'd0, d});
  endtask

  logic             exp_sel  [4];
  logic [WIDTH-1:0] exp_data [4];

  initial begin
    RSTn      = 1'b0;
    I0_VALID  = 1'b0;
    I0_DATA   = '0;
    I1_VALID  = 1'b0;
    I1_DATA   = '0;
    OUT_READY = 1'b0;
    exp_sel  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{4'd1, 4'd9, 4'd2, 4'd10};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    chk_out("reset_state", 1'b0, 1'b0, 4'h0);

    // Idle after reset: nothing valid, nothing granted
    OUT_READY = 1'b1;
    @(negedge CLK); #1;
    chk_ready("idle", 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk("idle_valid", {31'd0, OUT_VALID}, 32'd0);

    // Single stream 1
    I1_VALID = 1'b1;
    I1_DATA  = 4'hA;
    @(negedge CLK); #1;
    chk_ready("single1", 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk_out("single1_out", 1'b1, 1'b1, 4'hA);
    I1_VALID = 1'b0;

    // Drain without refill: SEL/data hold
    @(negedge CLK); #1;
    chk_ready("drain", 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk_out("drain_out", 1'b0, 1'b1, 4'hA);

    // PRIO stayed 0 after the stream-1 grant: contention goes to stream 0
    I0_VALID = 1'b1; I0_DATA = 4'h3;
    I1_VALID = 1'b1; I1_DATA = 4'h7;
    @(negedge CLK); #1;
    chk_ready("prio0", 1'b1, 1'b0);
    @(posedge CLK); #1;
    chk_out("prio0_out", 1'b1, 1'b0, 4'h3);

    // Asynchronous reset mid-cycle with a buffered word and PRIO=1
    @(negedge CLK); #2;
    RSTn = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 4'h0);
    chk_ready("async_rst", 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk_out("rst_held", 1'b0, 1'b0, 4'h0);
    chk_ready("rst_held", 1'b0, 1'b0);

    // Contention from reset: alternating grants with no bubble
    I0_DATA = 4'd1;
    I1_DATA = 4'd9;
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      chk_ready($sformatf("rr%0d", i), !exp_sel[i], exp_sel[i]);
      @(posedge CLK); #1;
      chk_out($sformatf("rr%0d_out", i), 1'b1, exp_sel[i], exp_data[i]);
      if (exp_sel[i]) I1_DATA = I1_DATA + 4'd1;
      else            I0_DATA = I0_DATA + 4'd1;
    end

    // Load 5 from stream 0 (PRIO=0), leaving PRIO=1
    I0_DATA = 4'h5;
    @(negedge CLK); #1;
    chk_ready("bp_load", 1'b1, 1'b0);
    @(posedge CLK); #1;
    chk_out("bp_load_out", 1'b1, 1'b0, 4'h5);

    // Back-pressure for 3 cycles; inputs change freely meanwhile
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      I0_DATA = 4'(4'h8 + i);
      I1_DATA = 4'(4'hB + i);
      @(negedge CLK); #1;
      chk_ready($sformatf("stall%0d", i), 1'b0, 1'b0);
      @(posedge CLK); #1;
      chk_out($sformatf("stall%0d_out", i), 1'b1, 1'b0, 4'h5);
    end

    // Release: stream 1 wins with its current word
    OUT_READY = 1'b1;
    I1_DATA   = 4'hC;
    @(negedge CLK); #1;
    chk_ready("release", 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk_out("release_out", 1'b1, 1'b1, 4'hC);

    // Uncontested stream-0 grant still flips PRIO to 1
    I1_VALID = 1'b0;
    I0_DATA  = 4'h4;
    @(negedge CLK); #1;
    chk_ready("unc0", 1'b1, 1'b0);
    @(posedge CLK); #1;
    chk_out("unc0_out", 1'b1, 1'b0, 4'h4);

    I0_DATA  = 4'h8;
    I1_VALID = 1'b1;
    I1_DATA  = 4'h2;
    @(negedge CLK); #1;
    chk_ready("after_unc0", 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk_out("after_unc0_out", 1'b1, 1'b1, 4'h2);

    // Final drain
    I0_VALID = 1'b0;
    I1_VALID = 1'b0;
    @(negedge CLK); #1;
    chk_ready("final", 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk_out("final_out", 1'b0, 1'b1, 4'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
